// File: rtl/fp_decode_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_decode_seq
// Description : Instruction sequencer/decoder between the instruction memory
//               and the floating-point ALU. Fetches a 16-bit word, decodes
//               [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2, issues ALU
//               ops with a start/done handshake, retires NOPs, stops on HALT.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CNT_W         width of the retired-instruction counter
// Ports:
//   Clock         system clock, rising edge
//   Reset         synchronous, active-high (shared with instruction memory)
//   run           start pulse, sampled only in IDLE
//   instructWord  memory read data, valid the cycle after readEn
//   readEn        memory read strobe
//   writeEn       memory write strobe, tied 0
//   PC_Inc        memory PC advance strobe
//   alu_start     one-cycle issue pulse to the FP ALU
//   alu_op        ALU operation (opcode[2:0])
//   rd/rs1/rs2    register indices from IR
//   alu_done      ALU completion, honoured only in EXEC
//   wb_en         one-cycle register-file write enable for rd
//   busy          high in every state except IDLE and HALTED
//   halted        high in HALTED
//   illegal       sticky illegal-opcode trap flag
//   instr_count   retired instructions (ALU ops and NOPs), wraps
// Build option:
//   DECODE_ILLEGAL_TRAP_EN  when defined, undefined opcodes halt with
//                           illegal=1; otherwise they retire as NOP.
// ============================================================================
module fp_decode_seq #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             run,
  input  logic [15:0]      instructWord,
  output logic             readEn,
  output logic             writeEn,
  output logic             PC_Inc,
  output logic             alu_start,
  output logic [2:0]       alu_op,
  output logic [3:0]       rd,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  input  logic             alu_done,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t           r_state;
  logic [15:0]      r_ir;
  logic             r_pc_inc;
  logic             r_wb_en;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  // Opcode classification of the word arriving in DECODE.
  logic [3:0] w_opcode;
  logic       w_is_alu;
  logic       w_is_nop;
  logic       w_is_halt;
  logic       w_is_undef;
  logic       w_retire_nop;
  logic       w_trap;
  logic       w_ir_unused;

  assign w_opcode   = instructWord[15:12];
  assign w_is_alu   = (w_opcode <= 4'd4);
  assign w_is_nop   = (w_opcode == 4'd5);
  assign w_is_halt  = (w_opcode == 4'd15);
  assign w_is_undef = !(w_is_alu || w_is_nop || w_is_halt);

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_trap       = w_is_undef;
  assign w_retire_nop = w_is_nop;
`else
  assign w_trap       = 1'b0;
  assign w_retire_nop = w_is_nop | w_is_undef;
`endif

  // alu_op carries only opcode[2:0]; the top IR bit has no consumer.
  assign w_ir_unused = r_ir[15];

  // PC_Inc and wb_en are registered, so each pulse appears the cycle after
  // the decision (DECODE or the alu_done cycle of EXEC). For a NOP/undefined
  // word PC_Inc therefore coincides with the next readEn; the memory must
  // read at the advanced address when both strobes are high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_ir      <= 16'h0000;
      r_pc_inc  <= 1'b0;
      r_wb_en   <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_pc_inc <= 1'b0;
      r_wb_en  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir <= instructWord;
          if (w_is_alu) begin
            r_pc_inc <= 1'b1;
            r_state  <= S_ISSUE;
          end else if (w_retire_nop) begin
            r_pc_inc <= 1'b1;
            r_count  <= r_count + c_one;
            r_state  <= S_FETCH;
          end else if (w_trap) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALTED;
          end else begin
            // HALT: PC is left pointing at the HALT word.
            r_state <= S_HALTED;
          end
        end
        S_ISSUE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (alu_done) begin
            r_wb_en <= 1'b1;
            r_count <= r_count + c_one;
            r_state <= S_FETCH;
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are state decodes or flops only; no input reaches an output
  // combinationally.
  assign readEn      = (r_state == S_FETCH);
  assign writeEn     = 1'b0;
  assign PC_Inc      = r_pc_inc;
  assign alu_start   = (r_state == S_ISSUE);
  assign wb_en       = r_wb_en;
  assign busy        = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_ISSUE) || (r_state == S_EXEC);
  assign halted      = (r_state == S_HALTED);
  assign illegal     = r_illegal;
  assign instr_count = r_count;
  assign alu_op      = r_ir[14:12];
  assign rd          = r_ir[11:8];
  assign rs1         = r_ir[7:4];
  assign rs2         = r_ir[3:0];

endmodule
`default_nettype wire

// File: tb/tb_fp_decode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_decode_seq
// Description : Self-checking bench for fp_decode_seq. Provides a 16-word
//               instruction memory and an ALU responder, runs directed and
//               random programs, and compares against a program-level model
//               (per-instruction cycle cost, retire count, issued tuples).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_decode_seq;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] instructWord;
  logic        readEn, writeEn, PC_Inc, alu_start;
  logic [2:0]  alu_op;
  logic [3:0]  rd, rs1, rs2;
  logic        alu_done;
  logic        wb_en, busy, halted, illegal;
  logic [15:0] instr_count;

  logic        man_done = 1'b0;
  logic        auto_done = 1'b0;
  assign alu_done = auto_done | man_done;

  fp_decode_seq #(.CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .run(run), .instructWord(instructWord),
    .readEn(readEn), .writeEn(writeEn), .PC_Inc(PC_Inc), .alu_start(alu_start),
    .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .alu_done(alu_done),
    .wb_en(wb_en), .busy(busy), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  // Instruction memory: 4-bit PC, read latency 1, reads at the advanced
  // address when PC_Inc and readEn coincide.
  logic [15:0] imem [16];
  logic [3:0]  mpc;
  logic [3:0]  mpc_nx;
  assign mpc_nx = mpc + {3'b000, PC_Inc};
  always @(posedge Clock) begin
    if (Reset) begin
      mpc          <= 4'd0;
      instructWord <= 16'hFFFF;
    end else begin
      mpc <= mpc_nx;
      if (readEn) instructWord <= imem[mpc_nx];
    end
  end

  // ALU responder: alu_done after dly_arr[n] EXEC cycles for the n-th issue.
  int dly_arr [256];
  int dly_ptr = 0;
  int rem = 0;
  always @(negedge Clock) begin
    if (Reset) begin
      rem = 0; auto_done = 1'b0;
    end else if (alu_start) begin
      rem = dly_arr[dly_ptr % 256]; dly_ptr = dly_ptr + 1; auto_done = 1'b0;
    end else if (rem > 0) begin
      auto_done = (rem == 1); rem = rem - 1;
    end else begin
      auto_done = 1'b0;
    end
  end

  // Event monitor.
  int n_start = 0, n_wb = 0, n_pcinc = 0, n_busy = 0, n_ovl = 0, n_nonmono = 0;
  logic [14:0] issue_arr [256];
  logic [15:0] prev_cnt = 16'd0;
  always @(negedge Clock) begin
    if (alu_start) begin
      issue_arr[n_start % 256] = {alu_op, rd, rs1, rs2};
      n_start = n_start + 1;
    end
    if (wb_en) n_wb = n_wb + 1;
    if (PC_Inc) n_pcinc = n_pcinc + 1;
    if (busy) n_busy = n_busy + 1;
    if (alu_start && wb_en) n_ovl = n_ovl + 1;
    if (!Reset && instr_count != prev_cnt && instr_count != prev_cnt + 16'd1)
      n_nonmono = n_nonmono + 1;
    prev_cnt = instr_count;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  function automatic logic [38:0] outs();
    return {readEn, writeEn, PC_Inc, alu_start, wb_en, busy, halted, illegal,
            alu_op, rd, rs1, rs2, instr_count};
  endfunction

  // Program-level reference model.
  int dl [16];
  int exp_cnt, exp_starts, exp_pcinc, exp_busy, exp_nq;
  bit exp_illegal;
  logic [14:0] exp_issue [32];

  task automatic model();
    int pc; int j; logic [15:0] w; int op;
    pc = 0; j = 0;
    exp_cnt = 0; exp_starts = 0; exp_pcinc = 0; exp_busy = 0; exp_nq = 0;
    exp_illegal = 1'b0;
    for (int s = 0; s < 64; s++) begin
      w  = imem[pc];
      op = int'(w[15:12]);
      if (op <= 4) begin
        exp_issue[exp_nq] = w[14:0]; exp_nq++;
        exp_busy += 3 + dl[j]; j++;
        exp_cnt++; exp_starts++; exp_pcinc++; pc = (pc + 1) % 16;
      end else if (op == 15) begin
        exp_busy += 2; break;
      end else if (op == 5 || !TRAP) begin
        exp_busy += 2; exp_cnt++; exp_pcinc++; pc = (pc + 1) % 16;
      end else begin
        exp_busy += 2; exp_illegal = 1'b1; break;
      end
    end
  endtask

  int b_start, b_wb, b_pcinc, b_busy;

  task automatic load_delays();
    for (int i = 0; i < 16; i++) dly_arr[(dly_ptr + i) % 256] = dl[i];
  endtask

  task automatic start_prog();
    Reset = 1'b1; tick(2); Reset = 1'b0;
    b_start = n_start; b_wb = n_wb; b_pcinc = n_pcinc; b_busy = n_busy;
    run = 1'b1; tick(1); run = 1'b0;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 600 && !halted; i++) tick(1);
  endtask

  task automatic check_run(input string tag);
    check({tag, " halted"}, halted, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " illegal"}, illegal, exp_illegal);
    check({tag, " count"}, instr_count, exp_cnt);
    check({tag, " starts"}, n_start - b_start, exp_starts);
    check({tag, " wb"}, n_wb - b_wb, exp_starts);
    check({tag, " pcinc"}, n_pcinc - b_pcinc, exp_pcinc);
    check({tag, " cycles"}, n_busy - b_busy, exp_busy);
    for (int i = 0; i < exp_nq; i++)
      check($sformatf("%s issue%0d", tag, i), issue_arr[(b_start + i) % 256], exp_issue[i]);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = 16'hFFFF;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [3:0]  op;
    int len, r;

    clear_mem();
    for (int i = 0; i < 256; i++) dly_arr[i] = 1;
    tick(2);
    check("reset outs", outs(), 39'd0);
    Reset = 1'b0;
    tick(1);
    check("idle outs", outs(), 39'd0);

    // FADD r1,r2,r3 then HALT, done 2 cycles after start.
    clear_mem(); imem[0] = 16'h0123;
    for (int i = 0; i < 16; i++) dl[i] = 2;
    load_delays(); model();
    start_prog(); wait_halt();
    check_run("fadd");
    check("fadd const count", instr_count, 1);
    check("fadd tuple", issue_arr[b_start % 256], 15'h0123);

    // Four NOPs then HALT.
    clear_mem(); for (int i = 0; i < 4; i++) imem[i] = 16'h5000;
    model();
    start_prog(); wait_halt();
    check_run("nop4");
    check("nop4 busy cycles", n_busy - b_busy, 10);

    // Undefined opcode.
    clear_mem(); imem[0] = 16'h7ABC;
    model();
    start_prog(); wait_halt();
    check_run("undef");
    check("undef const illegal", illegal, TRAP);
    check("undef const count", instr_count, TRAP ? 0 : 1);

    // Reset in EXEC before alu_done, then a stray alu_done.
    clear_mem(); imem[0] = 16'h0123;
    for (int i = 0; i < 16; i++) dl[i] = 10;
    load_delays();
    start_prog();
    for (int i = 0; i < 20 && !alu_start; i++) tick(1);
    check("rst seen start", alu_start, 1);
    tick(2);
    Reset = 1'b1; tick(1); Reset = 1'b0;
    check("rst outs", outs(), 39'd0);
    man_done = 1'b1; tick(1); man_done = 1'b0; tick(2);
    check("rst no wb", n_wb - b_wb, 0);
    check("rst outs after done", outs(), 39'd0);

    // 16 FMULs across PC wrap, done delay 1; word 0 becomes HALT after use.
    clear_mem();
    for (int i = 0; i < 16; i++) begin
      rnd = $urandom; imem[i] = {4'h2, rnd[11:0]};
      exp_issue[i] = imem[i][14:0];
      dl[i] = 1;
    end
    load_delays();
    start_prog();
    for (int i = 0; i < 60 && n_wb == b_wb; i++) tick(1);
    imem[0] = 16'hFFFF;
    wait_halt();
    exp_cnt = 16; exp_starts = 16; exp_pcinc = 16; exp_busy = 16 * 4 + 2;
    exp_nq = 16; exp_illegal = 1'b0;
    check_run("wrap");

    // alu_done held high and run pulsed while halted.
    clear_mem();
    man_done = 1'b1;
    start_prog(); wait_halt();
    run = 1'b1; tick(3); run = 1'b0; tick(3);
    check("hold halted", halted, 1);
    check("hold busy", busy, 0);
    check("hold wb", n_wb - b_wb, 0);
    check("hold count", instr_count, 0);
    man_done = 1'b0;

    // Random programs.
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 5) op = 4'(r);
        else if (r < 7) op = 4'd5;
        else op = 4'($urandom_range(6, 14));
        rnd = $urandom;
        imem[i] = {op, rnd[11:0]};
      end
      for (int i = 0; i < 16; i++) dl[i] = $urandom_range(1, 4);
      load_delays(); model();
      start_prog(); wait_halt();
      check_run($sformatf("rand%0d", t));
    end

    check("write strobe", writeEn, 0);
    check("start/wb overlap", n_ovl, 0);
    check("count monotonic", n_nonmono, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_decode_seq.md
# fp_decode_seq

Instruction sequencer and decoder sitting directly downstream of the instruction memory. It drives the memory's read and PC-advance strobes and captures the returned 16-bit instruction word. It splits the word into opcode and register fields and issues each operation to the floating-point ALU with a start/done handshake. It stops on HALT, and optionally traps on undefined opcodes.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high; shared with instruction memory
- run  in  1  start pulse; sampled only in IDLE
- instructWord  in  16  word from instruction memory, valid the cycle after readEn
- readEn  out  1  memory read strobe
- writeEn  out  1  memory write strobe; constant 0
- PC_Inc  out  1  memory PC advance strobe
- alu_start  out  1  one-cycle issue pulse to FP ALU
- alu_op  out  3  ALU operation code (opcode[2:0])
- rd, rs1, rs2  out  4 each  destination and source register indices
- alu_done  in  1  ALU completion, sampled only in EXEC
- wb_en  out  1  one-cycle register-file write enable for rd
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- illegal  out  1  sticky; set on illegal-opcode trap
- instr_count  out  CNT_W  retired instructions (ALU ops and NOPs)

## Operation
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
- Opcodes:
  - 0000 FADD, 0001 FSUB, 0010 FMUL, 0011 FDIV, 0100 FCMP (ALU ops)
  - 0101 NOP
  - 0110–1110 undefined
  - 1111 HALT
- The memory's reset word 0xFFFF therefore decodes as HALT.
- IR: internal 16-bit register; it is loaded only in DECODE. rd, rs1, rs2 and alu_op are driven from IR continuously.
- States: IDLE, FETCH, DECODE, ISSUE, EXEC, HALTED.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: readEn=1 -> DECODE.
- DECODE: IR <= instructWord, then:
  - ALU op: PC_Inc=1 -> ISSUE
  - NOP: PC_Inc=1, instr_count+1 -> FETCH
  - HALT: no PC_Inc -> HALTED; PC stays on the HALT word
  - undefined: see Configuration
- ISSUE: alu_start=1 for exactly one cycle -> EXEC.
- EXEC: hold until alu_done=1. On that cycle: wb_en=1, instr_count+1 -> FETCH.
- HALTED: terminal; only Reset leaves it. run is ignored.
- instr_count wraps from 2^CNT_W−1 to 0.
- The PC (4-bit, in memory) wraps from 15 to 0 with no special action here.

## Timing
- Reset values:
  - readEn, writeEn, PC_Inc, alu_start, wb_en, busy, halted, illegal = 0
  - alu_op, rd, rs1, rs2 = 0 (IR = 0)
  - instr_count = 0
  - state = IDLE
- All outputs are registered or decoded from the registered state. No combinational path from any input to any output.
- Memory read latency is 1: readEn in cycle t, instructWord valid in cycle t+1 (DECODE).
- ALU instruction takes 3 + k cycles, where k ≥ 1 is the number of EXEC cycles including the alu_done cycle.
- NOP takes 2 cycles. HALT reaches HALTED 2 cycles after leaving IDLE/FETCH.
- alu_done in any state other than EXEC is ignored.
- alu_start and wb_en never assert in the same cycle.
- Reset mid-instruction (any state) returns to IDLE next edge with all reset values; the in-flight ALU op is abandoned (no wb_en).
- Reset dominates run and alu_done in the same cycle.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: an undefined opcode in DECODE goes to HALTED with illegal=1, no PC_Inc, no count.
- Not defined: an undefined opcode is treated exactly as NOP (PC_Inc, count+1, -> FETCH). illegal stays 0 permanently.

## Test plan
- Program: FADD r1,r2,r3 (0x0123) then HALT; alu_done 2 cycles after alu_start -> alu_start once with alu_op=0, rd=1, rs1=2, rs2=3; wb_en one cycle; instr_count=1; halted=1; busy=0.
- Four NOPs (0x5000) then HALT -> PC_Inc pulses exactly 4 times, instr_count=4, no alu_start, NOP period exactly 2 cycles.
- Word 0x7ABC with macro defined -> halted=1, illegal=1, instr_count=0. Same word without macro -> treated as NOP, instr_count=1, illegal=0.
- Reset asserted in EXEC while alu_done is still low, then alu_done pulsed -> no wb_en; state IDLE; all outputs at reset values.
- 16 FMULs (0x2xxx) looping through PC wrap, ALU done delay 1 -> run continues past PC 15 -> 0; each instruction exactly 4 cycles; instr_count increments monotonically.
- alu_done held high continuously and run pulsed while halted -> no spurious wb_en outside EXEC; HALTED never exits without Reset.
